// File: rtl/cache_arb_pkg.sv
// Shared definitions for the I/D cache-to-memory arbiter: FSM state encoding,
// memory access-type codes and the data value returned on a watchdog abort.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [63:0] ERR_DATA = '0;

endpackage

// File: rtl/arb_watchdog.sv
// Memory-wait watchdog: counts granted cycles without an ack and flags expiry
// combinationally on the edge where the count would reach TIMEOUT.
module arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expire on the increment that lands on TIMEOUT, so the request stays up exactly TIMEOUT cycles.
  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an I-cache refill port
// and a D-cache read/write port, with a per-transaction watchdog abort.
module mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 30,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iIReq,
  input  logic [ADDR_W-1:0] iIAddr,
  output logic [DATA_W-1:0] oIData,
  output logic              oIAck,
  input  logic              iDReq,
  input  logic              iDRW,
  input  logic [ADDR_W-1:0] iDAddr,
  input  logic [DATA_W-1:0] iDWData,
  output logic [DATA_W-1:0] oDData,
  output logic              oDAck,
  output logic              oMemReq,
  output logic              oMemRW,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic [DATA_W-1:0] iMemRData,
  input  logic              iMemAck,
  output logic              oErr
);

  arb_state_e r_state;
  logic       r_last_d;
  logic       w_ireq;
  logic       w_dreq;
  logic       w_grant_i;
  logic       w_grant_d;
  logic       w_busy;
  logic       w_expire;

  // A side whose ack is visible this cycle is still holding its request; ignore it once.
  assign w_ireq    = iIReq & ~oIAck;
  assign w_dreq    = iDReq & ~oDAck;
  assign w_grant_d = (r_state == IDLE) && w_dreq && (!w_ireq || !r_last_d);
  assign w_grant_i = (r_state == IDLE) && w_ireq && !w_grant_d;
  assign w_busy    = (r_state != IDLE);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clk    (iCLK),
    .i_rst    (iRST),
    .i_clr    (w_grant_i | w_grant_d),
    .i_en     (w_busy & ~iMemAck),
    .o_expire (w_expire)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      oIData    <= '0;
      oIAck     <= 1'b0;
      oDData    <= '0;
      oDAck     <= 1'b0;
      oMemReq   <= 1'b0;
      oMemRW    <= 1'b0;
      oMemAddr  <= '0;
      oMemWData <= '0;
      oErr      <= 1'b0;
    end else begin
      oIAck <= 1'b0;
      oDAck <= 1'b0;
      oErr  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state   <= GNT_D;
            r_last_d  <= 1'b1;
            oMemReq   <= 1'b1;
            oMemRW    <= iDRW;
            oMemAddr  <= iDAddr;
            oMemWData <= iDWData;
          end else if (w_grant_i) begin
            r_state   <= GNT_I;
            r_last_d  <= 1'b0;
            oMemReq   <= 1'b1;
            oMemRW    <= RW_READ;
            oMemAddr  <= iIAddr;
            oMemWData <= '0;
          end
        end
        GNT_I, GNT_D: begin
          // An ack on the expiry edge wins: w_expire is already gated by ~iMemAck.
          if (iMemAck || w_expire) begin
            r_state <= IDLE;
            oMemReq <= 1'b0;
            oErr    <= ~iMemAck;
            if (r_state == GNT_I) begin
              oIAck  <= 1'b1;
              oIData <= iMemAck ? iMemRData : DATA_W'(ERR_DATA);
            end else begin
              oDAck <= 1'b1;
              if (!iMemAck) begin
                oDData <= DATA_W'(ERR_DATA);
              end else if (oMemRW == RW_READ) begin
                oDData <= iMemRData;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter, built with a short watchdog
// so the abort and ack-on-expiry-edge cases are reachable in a few cycles.
module tb_mem_arbiter;
  import cache_arb_pkg::*;

  localparam int unsigned ADDR_W  = 30;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;

  logic              iCLK;
  logic              iRST;
  logic              iIReq;
  logic [ADDR_W-1:0] iIAddr;
  logic [DATA_W-1:0] oIData;
  logic              oIAck;
  logic              iDReq;
  logic              iDRW;
  logic [ADDR_W-1:0] iDAddr;
  logic [DATA_W-1:0] iDWData;
  logic [DATA_W-1:0] oDData;
  logic              oDAck;
  logic              oMemReq;
  logic              oMemRW;
  logic [ADDR_W-1:0] oMemAddr;
  logic [DATA_W-1:0] oMemWData;
  logic [DATA_W-1:0] iMemRData;
  logic              iMemAck;
  logic              oErr;

  int unsigned n_checks;
  int unsigned n_fail;

  mem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iIReq     (iIReq),
    .iIAddr    (iIAddr),
    .oIData    (oIData),
    .oIAck     (oIAck),
    .iDReq     (iDReq),
    .iDRW      (iDRW),
    .iDAddr    (iDAddr),
    .iDWData   (iDWData),
    .oDData    (oDData),
    .oDAck     (oDAck),
    .oMemReq   (oMemReq),
    .oMemRW    (oMemRW),
    .oMemAddr  (oMemAddr),
    .oMemWData (oMemWData),
    .iMemRData (iMemRData),
    .iMemAck   (iMemAck),
    .oErr      (oErr)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs driven 1 time unit after it.
  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    iRST      = 1'b0;
    iIReq     = 1'b0;
    iIAddr    = '0;
    iDReq     = 1'b0;
    iDRW      = RW_READ;
    iDAddr    = '0;
    iDWData   = '0;
    iMemRData = '0;
    iMemAck   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_eq("rst_memreq", oMemReq, 0);
    chk_eq("rst_memrw", oMemRW, 0);
    chk_eq("rst_memaddr", oMemAddr, 0);
    chk_eq("rst_memwdata", oMemWData, 0);
    chk_eq("rst_acks", {oIAck, oDAck, oErr}, 0);
    chk_eq("rst_data", {oIData, oDData}, 0);
    iRST = 1'b1;

    // Single I read, ack 3 cycles into the grant
    iIReq  = 1'b1;
    iIAddr = 30'h10;
    tick();
    chk_eq("i_req", oMemReq, 1);
    chk_eq("i_rw", oMemRW, RW_READ);
    chk_eq("i_addr", oMemAddr, 30'h10);
    tick();
    tick();
    chk_eq("i_req_held", oMemReq, 1);
    chk_eq("i_no_early_ack", oIAck, 0);
    iMemAck   = 1'b1;
    iMemRData = 32'hCAFEF00D;
    tick();
    chk_eq("i_ack", oIAck, 1);
    chk_eq("i_data", oIData, 32'hCAFEF00D);
    chk_eq("i_req_drop", oMemReq, 0);
    chk_eq("i_no_err", oErr, 0);
    iMemAck = 1'b0;
    tick();
    chk_eq("i_masked_req", oMemReq, 0);
    chk_eq("i_ack_pulse", oIAck, 0);
    iIReq = 1'b0;
    tick();

    // D read to load oDData, then a D write that must not disturb it
    iDReq  = 1'b1;
    iDRW   = RW_READ;
    iDAddr = 30'h30;
    tick();
    chk_eq("dr_rw", oMemRW, RW_READ);
    chk_eq("dr_addr", oMemAddr, 30'h30);
    iMemAck   = 1'b1;
    iMemRData = 32'h55AA55AA;
    tick();
    chk_eq("dr_ack", oDAck, 1);
    chk_eq("dr_data", oDData, 32'h55AA55AA);
    iMemAck = 1'b0;
    iDReq   = 1'b0;
    tick();
    iDReq   = 1'b1;
    iDRW    = RW_WRITE;
    iDAddr  = 30'h20;
    iDWData = 32'h12345678;
    tick();
    chk_eq("dw_req", oMemReq, 1);
    chk_eq("dw_rw", oMemRW, RW_WRITE);
    chk_eq("dw_addr", oMemAddr, 30'h20);
    chk_eq("dw_wdata", oMemWData, 32'h12345678);
    iMemAck   = 1'b1;
    iMemRData = 32'hDEADBEEF;
    tick();
    chk_eq("dw_ack", oDAck, 1);
    chk_eq("dw_data_kept", oDData, 32'h55AA55AA);
    iMemAck = 1'b0;
    iDReq   = 1'b0;
    tick();

    // Both requesting out of reset: D, I, D, I with one idle cycle between
    iRST = 1'b0;
    tick();
    iRST   = 1'b1;
    iIReq  = 1'b1;
    iIAddr = 30'h100;
    iDReq  = 1'b1;
    iDRW   = RW_READ;
    iDAddr = 30'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_eq("rr_req", oMemReq, 1);
      chk_eq("rr_addr", oMemAddr, (k % 2 == 0) ? 30'h200 : 30'h100);
      iMemAck   = 1'b1;
      iMemRData = 32'hA0000000 + 32'(k);
      tick();
      chk_eq("rr_gap", oMemReq, 0);
      chk_eq("rr_dack", oDAck, (k % 2 == 0) ? 1 : 0);
      chk_eq("rr_iack", oIAck, (k % 2 == 0) ? 0 : 1);
      iMemAck = 1'b0;
    end
    chk_eq("rr_idata", oIData, 32'hA0000003);
    chk_eq("rr_ddata", oDData, 32'hA0000002);
    iIReq = 1'b0;
    iDReq = 1'b0;
    tick();

    // Watchdog abort: request held exactly TIMEOUT cycles, then I ack with error
    iIReq  = 1'b1;
    iIAddr = 30'h40;
    tick();
    for (int c = 1; c < 4; c++) begin
      tick();
      chk_eq("to_req_held", oMemReq, 1);
      chk_eq("to_no_ack", oIAck, 0);
    end
    tick();
    chk_eq("to_req_drop", oMemReq, 0);
    chk_eq("to_iack", oIAck, 1);
    chk_eq("to_err", oErr, 1);
    chk_eq("to_idata", oIData, 0);
    iIReq     = 1'b0;
    iMemAck   = 1'b1;
    iMemRData = 32'h77777777;
    tick();
    chk_eq("late_ack_req", oMemReq, 0);
    chk_eq("late_ack_acks", {oIAck, oDAck, oErr}, 0);
    chk_eq("late_ack_idata", oIData, 0);
    chk_eq("late_ack_ddata", oDData, 32'hA0000002);
    iMemAck = 1'b0;
    tick();

    // Ack on the edge where the watchdog would expire: normal completion
    iDReq  = 1'b1;
    iDRW   = RW_READ;
    iDAddr = 30'h50;
    tick();
    tick();
    tick();
    tick();
    chk_eq("edge_req_held", oMemReq, 1);
    iMemAck   = 1'b1;
    iMemRData = 32'h0BADF00D;
    tick();
    chk_eq("edge_dack", oDAck, 1);
    chk_eq("edge_no_err", oErr, 0);
    chk_eq("edge_ddata", oDData, 32'h0BADF00D);
    iMemAck = 1'b0;
    iDReq   = 1'b0;
    tick();

    // Reset during a D grant abandons it; D is then re-served
    iDReq  = 1'b1;
    iDRW   = RW_READ;
    iDAddr = 30'h60;
    tick();
    chk_eq("mid_req", oMemReq, 1);
    iRST = 1'b0;
    tick();
    chk_eq("mid_rst_req", oMemReq, 0);
    chk_eq("mid_rst_acks", {oIAck, oDAck, oErr}, 0);
    chk_eq("mid_rst_addr", oMemAddr, 0);
    chk_eq("mid_rst_data", {oIData, oDData}, 0);
    iRST = 1'b1;
    tick();
    chk_eq("reserve_req", oMemReq, 1);
    chk_eq("reserve_addr", oMemAddr, 30'h60);
    iMemAck   = 1'b1;
    iMemRData = 32'h0000600D;
    tick();
    chk_eq("reserve_dack", oDAck, 1);
    chk_eq("reserve_ddata", oDData, 32'h0000600D);
    chk_eq("reserve_err", oErr, 0);
    iMemAck = 1'b0;
    iDReq   = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
